// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchronizer feeding a four-state qualify FSM.
// A level change must hold for STABLE_COUNT cycles before Debounced follows.
// Aborted qualifications are tallied in a saturating GlitchCount.
module switch_debouncer #(
  parameter int STABLE_COUNT = 50000,
  parameter int COUNT_WIDTH  = 16,
  parameter int GLITCH_WIDTH = 8
) (
  input  logic                    CLOCK,
  input  logic                    Reset,
  input  logic                    NoisyIn,
  input  logic                    ClearGlitch,
  output logic                    Debounced,
  output logic                    Busy,
  output logic [GLITCH_WIDTH-1:0] GlitchCount
);

  localparam logic [COUNT_WIDTH-1:0]  CNT_MAX    = COUNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t                  state, nextState;
  logic [1:0]              syncPipe;
  logic                    s;
  logic [COUNT_WIDTH-1:0]  cnt, cntNext;
  logic                    glitchInc;

  assign s = syncPipe[1];

  // Two-flop synchronizer; only the second stage reaches the FSM.
  always_ff @(posedge CLOCK) begin
    if (Reset) syncPipe <= 2'b00;
    else       syncPipe <= {syncPipe[0], NoisyIn};
  end

  // State and stability counter registers.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  // Next-state logic: a bounce during qualification falls back to the idle state.
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    glitchInc = 1'b0;
    unique case (state)
      IDLE_LOW: if (s) begin
        nextState = WAIT_HIGH;
        cntNext   = '0;
      end
      WAIT_HIGH: begin
        if (!s) begin
          nextState = IDLE_LOW;
          glitchInc = 1'b1;
        end else if (cnt == CNT_MAX) begin
          nextState = IDLE_HIGH;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      IDLE_HIGH: if (!s) begin
        nextState = WAIT_LOW;
        cntNext   = '0;
      end
      WAIT_LOW: begin
        if (s) begin
          nextState = IDLE_HIGH;
          glitchInc = 1'b1;
        end else if (cnt == CNT_MAX) begin
          nextState = IDLE_LOW;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: nextState = IDLE_LOW;
    endcase
  end

  // Saturating abort counter; a clear overrides a same-cycle increment.
  always_ff @(posedge CLOCK) begin
    if (Reset)                                    GlitchCount <= '0;
    else if (ClearGlitch)                         GlitchCount <= '0;
    else if (glitchInc && GlitchCount != GLITCH_MAX) GlitchCount <= GlitchCount + 1'b1;
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    Debounced = (state == IDLE_HIGH) || (state == WAIT_LOW);
    Busy      = (state == WAIT_HIGH) || (state == WAIT_LOW);
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_COUNT=4.
module tb_switch_debouncer;

  logic       CLOCK = 1'b0;
  logic       Reset;
  logic       NoisyIn;
  logic       ClearGlitch;
  logic       Debounced;
  logic       Busy;
  logic [7:0] GlitchCount;

  int vectors    = 0;
  int miscompares = 0;
  int badDeb;

  switch_debouncer #(.STABLE_COUNT(4), .COUNT_WIDTH(16), .GLITCH_WIDTH(8)) dut (
    .CLOCK(CLOCK), .Reset(Reset), .NoisyIn(NoisyIn), .ClearGlitch(ClearGlitch),
    .Debounced(Debounced), .Busy(Busy), .GlitchCount(GlitchCount)
  );

  always #5 CLOCK = ~CLOCK;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; NoisyIn = 1'b1; ClearGlitch = 1'b0;

    // Reset held with input high: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_deb",    32'(Debounced),   32'd0);
      chk("rst_busy",   32'(Busy),        32'd0);
      chk("rst_glitch", 32'(GlitchCount), 32'd0);
    end

    // Release with input still high: re-qualified, rises after edge 6.
    Reset = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      step();
      chk("requal_busy", 32'(Busy),      32'(i >= 2 && i <= 5));
      chk("requal_deb",  32'(Debounced), 32'(i >= 6));
    end

    // Falling edge: Debounced drops exactly 6 edges after first low sample.
    NoisyIn = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      step();
      chk("fall_busy", 32'(Busy),      32'(i >= 2 && i <= 5));
      chk("fall_deb",  32'(Debounced), 32'(i < 6));
    end

    // Clean press from low.
    NoisyIn = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      chk("rise_busy", 32'(Busy),      32'(i >= 2 && i <= 5));
      chk("rise_deb",  32'(Debounced), 32'(i >= 6));
    end
    chk("rise_glitch", 32'(GlitchCount), 32'd0);

    // Bounce while releasing: 3 low then 5 high, Debounced stays 1.
    for (int i = 0; i < 8; i++) begin
      NoisyIn = (i >= 3);
      step();
      chk("wlow_bounce_deb", 32'(Debounced), 32'd1);
    end
    chk("wlow_bounce_glitch", 32'(GlitchCount), 32'd1);
    chk("wlow_bounce_busy",   32'(Busy),        32'd0);

    // Settle low again.
    NoisyIn = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("settle_low_deb", 32'(Debounced), 32'd0);

    // Bounce while pressing: 3 high then 5 low, Debounced stays 0.
    for (int i = 0; i < 8; i++) begin
      NoisyIn = (i < 3);
      step();
      chk("whigh_bounce_deb", 32'(Debounced), 32'd0);
    end
    chk("whigh_bounce_glitch", 32'(GlitchCount), 32'd2);

    // 300 single-cycle pulses: counter saturates, never wraps.
    badDeb = 0;
    for (int p = 0; p < 300; p++) begin
      NoisyIn = 1'b1;
      step();
      if (Debounced !== 1'b0) badDeb++;
      NoisyIn = 1'b0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (Debounced !== 1'b0) badDeb++;
      end
    end
    chk("pulse_deb_samples", 32'(badDeb),      32'd0);
    chk("pulse_saturate",    32'(GlitchCount), 32'd255);

    // Clear coincident with an abort: clear wins.
    NoisyIn = 1'b1; step();           // edge 0
    NoisyIn = 1'b0; step();           // edge 1
    step();                           // edge 2 -> WAIT_HIGH
    chk("clr_wait_busy", 32'(Busy), 32'd1);
    ClearGlitch = 1'b1; step();       // edge 3 abort + clear
    ClearGlitch = 1'b0;
    chk("clr_vs_abort", 32'(GlitchCount), 32'd0);
    chk("clr_busy",     32'(Busy),        32'd0);

    // Plain abort after clear counts from zero.
    NoisyIn = 1'b1; step();
    NoisyIn = 1'b0; step(); step(); step();
    chk("abort_after_clr", 32'(GlitchCount), 32'd1);
    ClearGlitch = 1'b1; step();
    ClearGlitch = 1'b0;
    chk("clr_alone", 32'(GlitchCount), 32'd0);

    // Reset in WAIT_HIGH aborts without counting.
    NoisyIn = 1'b1;
    step(); step(); step();
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    Reset = 1'b1; step();
    chk("midq_rst_busy",   32'(Busy),        32'd0);
    chk("midq_rst_deb",    32'(Debounced),   32'd0);
    chk("midq_rst_glitch", 32'(GlitchCount), 32'd0);
    Reset = 1'b0; step();
    chk("post_rst_busy",   32'(Busy),        32'd0);
    chk("post_rst_glitch", 32'(GlitchCount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
